// File: rtl/lsu_pkg.sv
// Shared encodings, FSM states and the alignment rule for the load/store unit.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_MERGE = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4
   } lsu_state_e;

   // Reserved size always faults; otherwise the offset must be a multiple of the access size.
   function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] offset);
      logic fault;
      case (size)
         SZ_BYTE: fault = 1'b0;
         SZ_HALF: fault = offset[0];
         SZ_WORD: fault = (offset != 2'b00);
         default: fault = 1'b1;
      endcase
      return fault;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between the word-wide memory and sub-word loads/stores.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_lane,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_load_data,
   output logic [31:0] o_merge_data
);

   function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic sgn);
      logic [31:0] shifted;
      logic [31:0] res;
      shifted = word >> {lane, 3'b000};
      case (size)
         SZ_BYTE: res = {{24{sgn & shifted[7]}}, shifted[7:0]};
         SZ_HALF: res = {{16{sgn & shifted[15]}}, shifted[15:0]};
         SZ_WORD: res = word;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   // Only the addressed lane(s) take the right-justified store data; the rest keep the read word.
   function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [1:0] lane,
                                              input logic [1:0] size, input logic [31:0] wdata);
      logic [31:0] mask;
      case (size)
         SZ_BYTE: mask = 32'h0000_00FF << {lane, 3'b000};
         SZ_HALF: mask = 32'h0000_FFFF << {lane, 3'b000};
         SZ_WORD: mask = 32'hFFFF_FFFF;
         default: mask = 32'h0000_0000;
      endcase
      return (word & ~mask) | ((wdata << {lane, 3'b000}) & mask);
   endfunction

   assign o_load_data  = lane_extract(i_word, i_lane, i_size, i_signed);
   assign o_merge_data = lane_merge(i_word, i_lane, i_size, i_wdata);

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: maps byte/half/word requests onto a word-only memory,
// using read-modify-write for sub-word stores.
module load_store_unit
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_fault,
   output logic        mem_wen,
   output logic        mem_ren,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_data_i,
   input  logic [31:0] mem_data_o
);

   lsu_state_e  r_state;
   lsu_state_e  w_next_state;
   logic [1:0]  r_size;
   logic        r_signed;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_mem_data;
   logic [31:0] r_rdata;
   logic        r_fault;
   logic        w_accept;
   logic        w_req_fault;
   logic [31:0] w_load_data;
   logic [31:0] w_merge_data;

   assign w_accept    = req_valid && (r_state == ST_IDLE);
   assign w_req_fault = lsu_misaligned(req_size, req_addr[1:0]);

   lsu_lane_align u_align (
      .i_word       (mem_data_o),
      .i_lane       (r_addr[1:0]),
      .i_size       (r_size),
      .i_signed     (r_signed),
      .i_wdata      (r_wdata),
      .o_load_data  (w_load_data),
      .o_merge_data (w_merge_data)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode; the accepted request alone chooses the path through the FSM
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (!w_accept) begin
               w_next_state = ST_IDLE;
            end else if (w_req_fault) begin
               w_next_state = ST_RESP;
            end else if (!req_we) begin
               w_next_state = ST_LOAD;
            end else if (req_size == SZ_WORD) begin
               w_next_state = ST_WRITE;
            end else begin
               w_next_state = ST_MERGE;
            end
         end
         ST_LOAD:  w_next_state = ST_RESP;
         ST_MERGE: w_next_state = ST_WRITE;
         ST_WRITE: w_next_state = ST_RESP;
         ST_RESP:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Request capture, load result and merged write word
   always_ff @(posedge clk) begin
      if (rst) begin
         r_size     <= 2'b00;
         r_signed   <= 1'b0;
         r_addr     <= 32'h0000_0000;
         r_wdata    <= 32'h0000_0000;
         r_mem_data <= 32'h0000_0000;
         r_rdata    <= 32'h0000_0000;
         r_fault    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_size   <= req_size;
                  r_signed <= req_signed;
                  r_addr   <= req_addr;
                  r_wdata  <= req_wdata;
                  r_fault  <= w_req_fault;
                  r_rdata  <= 32'h0000_0000;
                  if (req_we) begin
                     r_mem_data <= req_wdata;
                  end
               end
            end
            ST_LOAD:  r_rdata    <= w_load_data;
            ST_MERGE: r_mem_data <= w_merge_data;
            ST_RESP: begin
               r_fault <= 1'b0;
               r_rdata <= 32'h0000_0000;
            end
            default: begin
            end
         endcase
      end
   end

   assign req_ready  = (r_state == ST_IDLE);
   assign resp_valid = (r_state == ST_RESP);
   assign resp_rdata = r_rdata;
   assign resp_fault = r_fault;
   assign mem_ren    = (r_state == ST_LOAD) || (r_state == ST_MERGE);
   assign mem_wen    = (r_state == ST_WRITE);
   assign mem_addr   = {r_addr[31:2], 2'b00};
   assign mem_data_i = r_mem_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-array reference memory plus a word-wide memory model behind the DUT.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_fault;
   logic        mem_wen;
   logic        mem_ren;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_i;
   logic [31:0] mem_data_o;

   logic [7:0]  ref_mem [256];
   logic [31:0] mem [64];
   logic        mem_init;
   int          errors = 0;
   int          checks = 0;
   int          n_wen = 0;
   int          n_ren = 0;
   int          n_both = 0;

   load_store_unit dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
      .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_data_i(mem_data_i),
      .mem_data_o(mem_data_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_word(input int idx);
      return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
   endfunction

   function automatic logic mdl_fault(input logic [1:0] size, input logic [31:0] addr);
      int n;
      if (size == 2'd3) return 1'b1;
      n = 1 << size;
      return (int'(addr[1:0]) % n) != 0;
   endfunction

   function automatic logic [31:0] mdl_load(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
      int n;
      int base;
      logic [31:0] v;
      n = 1 << size;
      base = int'(addr[7:0]);
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[base + i]) << (8 * i));
      if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   // Word memory: writes land on the falling edge, reads are combinational
   always @(negedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= ref_word(i);
      end else if (mem_wen) begin
         mem[mem_addr[7:2]] <= mem_data_i;
      end
   end
   assign mem_data_o = mem_ren ? mem[mem_addr[7:2]] : 32'h0;

   always @(posedge clk) begin
      if (mem_wen) n_wen <= n_wen + 1;
      if (mem_ren) n_ren <= n_ren + 1;
      if (mem_wen && mem_ren) n_both <= n_both + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
      logic        flt;
      logic [31:0] exp_rd;
      int          exp_lat;
      int          lat;
      int          wen0;
      int          ren0;
      logic        got;
      flt = mdl_fault(size, addr);
      exp_rd = (flt || we) ? 32'h0 : mdl_load(size, sgn, addr);
      exp_lat = flt ? 1 : ((!we || size == 2'd2) ? 2 : 3);
      if (!flt && we) begin
         for (int i = 0; i < (1 << size); i++) ref_mem[int'(addr[7:0]) + i] = 8'(wdata >> (8 * i));
      end
      @(negedge clk);
      check("ready", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
      req_addr = addr; req_wdata = wdata;
      wen0 = n_wen; ren0 = n_ren;
      @(posedge clk);
      #1 req_valid = 1'b0;
      lat = 0; got = 1'b0; rdata = 32'h0;
      for (int c = 0; c < 8 && !got; c++) begin
         @(negedge clk);
         lat++;
         if (mem_wen || mem_ren) check("mem_addr", mem_addr, {addr[31:2], 2'b00});
         if (mem_wen) check("mem_data_i", mem_data_i, ref_word(int'(addr[7:2])));
         if (resp_valid) begin
            got = 1'b1;
            rdata = resp_rdata;
            check("fault", 32'(resp_fault), 32'(flt));
            check("rdata", resp_rdata, exp_rd);
         end
      end
      check("resp_seen", 32'(got), 32'd1);
      check("latency", 32'(lat), 32'(exp_lat));
      check("wen_cycles", 32'(n_wen - wen0), 32'((!flt && we) ? 1 : 0));
      check("ren_cycles", 32'(n_ren - ren0), 32'((!flt && (!we || size != 2'd2)) ? 1 : 0));
      @(negedge clk);
      check("resp_pulse", 32'(resp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] w8;
      logic [31:0] a;
      logic [1:0]  sz;
      int          wen0;
      int          ren0;
      int          acc_cyc [4];
      logic [31:0] bb_exp [4];
      int          nacc;
      int          nresp;
      logic        prev_rv;

      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_signed = 1'b0;
      req_addr = 32'h0; req_wdata = 32'h0; mem_init = 1'b1;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
      @(negedge clk);
      #1 mem_init = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_resp_fault", 32'(resp_fault), 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_mem_wen", 32'(mem_wen), 32'd0);
      check("rst_mem_ren", 32'(mem_ren), 32'd0);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_data_i", mem_data_i, 32'h0);
      rst = 1'b0;

      do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd);
      do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd);
      check("lw_deadbeef", rd, 32'hDEADBEEF);

      do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11223344, rd);
      do_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h000000AA, rd);
      check("sb_merge_word", mem[8], 32'h1122AA44);
      do_req(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, rd);
      check("lb_signed", rd, 32'hFFFFFFAA);
      do_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0, rd);
      check("lbu", rd, 32'h000000AA);

      do_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h0, rd);
      do_req(1'b1, 2'd1, 1'b0, 32'h22, 32'h00008001, rd);
      check("sh_merge_word", mem[8], 32'h80010000);
      do_req(1'b0, 2'd1, 1'b1, 32'h22, 32'h0, rd);
      check("lh_signed", rd, 32'hFFFF8001);
      do_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, rd);
      check("lhu", rd, 32'h00008001);

      w8 = mem[8];
      do_req(1'b0, 2'd2, 1'b0, 32'h13, 32'h0, rd);
      do_req(1'b1, 2'd1, 1'b0, 32'h21, 32'h00001234, rd);
      do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, rd);
      do_req(1'b1, 2'd3, 1'b0, 32'h20, 32'hCAFEF00D, rd);
      check("fault_mem_unchanged", mem[8], w8);

      // Reset while the sub-word store sits in MERGE
      w8 = mem[8];
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
      req_addr = 32'h21; req_wdata = 32'h55;
      wen0 = n_wen;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      check("in_merge_ren", 32'(mem_ren), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_abort_ready", 32'(req_ready), 32'd1);
      check("rst_abort_wen", 32'(mem_wen), 32'd0);
      for (int c = 0; c < 4; c++) begin
         check("rst_abort_no_resp", 32'(resp_valid), 32'd0);
         @(negedge clk);
      end
      check("rst_abort_wen_cycles", 32'(n_wen - wen0), 32'd0);
      check("rst_abort_mem", mem[8], w8);

      // Request presented together with reset is dropped
      ren0 = n_ren;
      rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
      @(negedge clk);
      rst = 1'b0; req_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_drop_ready", 32'(req_ready), 32'd1);
      check("rst_drop_ren", 32'(n_ren - ren0), 32'd0);

      // Back-to-back word loads with req_valid held high
      nacc = 0; nresp = 0; prev_rv = 1'b0;
      for (int c = 0; c < 40 && nresp < 4; c++) begin
         if (resp_valid) begin
            check("b2b_rdata", resp_rdata, bb_exp[nresp]);
            check("b2b_single_pulse", 32'(prev_rv), 32'd0);
            nresp++;
         end
         prev_rv = resp_valid;
         if (req_ready) begin
            if (nacc < 4) begin
               a = {$urandom_range(0, 255) & 32'hFC};
               req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = a;
               bb_exp[nacc] = mdl_load(2'd2, 1'b0, a);
               acc_cyc[nacc] = c;
               nacc++;
            end else begin
               req_valid = 1'b0;
            end
         end
         if (nresp < 4) @(negedge clk);
      end
      req_valid = 1'b0;
      check("b2b_responses", 32'(nresp), 32'd4);
      for (int k = 1; k < 4; k++) check("b2b_spacing", 32'(acc_cyc[k] - acc_cyc[k-1]), 32'd3);
      @(negedge clk);
      check("b2b_last_pulse", 32'(resp_valid), 32'd0);

      // Randomized mix against the byte-level reference
      for (int t = 0; t < 60; t++) begin
         sz = 2'($urandom_range(0, 3));
         a = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'd1) a[0] = 1'b0;
            if (sz == 2'd2) a[1:0] = 2'b00;
         end
         do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd);
      end

      for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_word(i));
      check("never_both_enables", 32'(n_both), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
